// File: rtl/simmem_addr_scheduler_if.sv
// Address-channel handshake bundle between requester, scheduler and delay calculator.
// Only valid/ready travel here; address payloads route around the scheduler.
interface simmem_addr_scheduler_if;
  logic waddr_valid_i;
  logic waddr_ready_o;
  logic raddr_valid_i;
  logic raddr_ready_o;
  logic core_waddr_valid_o;
  logic core_waddr_ready_i;
  logic core_raddr_valid_o;
  logic core_raddr_ready_i;

  modport slave (
    input  waddr_valid_i, raddr_valid_i, core_waddr_ready_i, core_raddr_ready_i,
    output waddr_ready_o, raddr_ready_o, core_waddr_valid_o, core_raddr_valid_o
  );

  modport master (
    output waddr_valid_i, raddr_valid_i, core_waddr_ready_i, core_raddr_ready_i,
    input  waddr_ready_o, raddr_ready_o, core_waddr_valid_o, core_raddr_valid_o
  );
endinterface

// File: rtl/simmem_addr_scheduler.sv
// Read/write address-handshake scheduler with turnaround, write batching and write-starvation bound.
// Optional statistics counters are built when SIMMEM_ADDR_SCHED_STATS_EN is defined.
module simmem_addr_scheduler #(
  parameter int unsigned TurnCycles = 2,
  parameter int unsigned WBatchLen  = 4,
  parameter int unsigned MaxWStarve = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  simmem_addr_scheduler_if.slave   bus,
  output logic [1:0]               mode_o,
  output logic [31:0]              stat_rd_grants_o,
  output logic [31:0]              stat_wr_grants_o,
  output logic [31:0]              stat_turns_o
);

  localparam int unsigned TurnW   = 4;
  localparam int unsigned BatchW  = 8;
  localparam int unsigned StarveW = 8;

  typedef enum logic [1:0] {
    StRd   = 2'd0,
    StWr   = 2'd1,
    StTurn = 2'd2
  } state_e;

  state_e               state_q, state_d;
  state_e               target_q, target_d;
  logic [TurnW-1:0]     turn_q, turn_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic [BatchW-1:0]    batch_q, batch_d;
  logic                 rd_pend_q, wr_pend_q;
  logic                 grant_rd, grant_wr;
  logic                 go_wr, go_rd;
  logic                 wr_hs;

  // Switch requests; an outstanding unaccepted valid pins the current direction.
  assign go_wr = bus.waddr_valid_i && !rd_pend_q &&
                 (!bus.raddr_valid_i || starve_q == StarveW'(MaxWStarve));
  assign go_rd = bus.raddr_valid_i && !wr_pend_q &&
                 (!bus.waddr_valid_i || batch_q == BatchW'(WBatchLen));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    turn_d   = turn_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state_q)
      StRd: begin
        if (go_wr) begin
          state_d  = StTurn;
          target_d = StWr;
          turn_d   = TurnW'(TurnCycles - 1);
        end else begin
          grant_rd = 1'b1;
        end
      end
      StWr: begin
        if (go_rd) begin
          state_d  = StTurn;
          target_d = StRd;
          turn_d   = TurnW'(TurnCycles - 1);
        end else begin
          grant_wr = 1'b1;
        end
      end
      StTurn: begin
        if (turn_q == '0) state_d = target_q;
        else              turn_d  = turn_q - TurnW'(1);
      end
      default: state_d = StRd;
    endcase
    if (!rst_ni) begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
    end
  end

  assign bus.core_raddr_valid_o = bus.raddr_valid_i & grant_rd;
  assign bus.core_waddr_valid_o = bus.waddr_valid_i & grant_wr;
  assign bus.raddr_ready_o      = bus.core_raddr_ready_i & grant_rd;
  assign bus.waddr_ready_o      = bus.core_waddr_ready_i & grant_wr;
  assign wr_hs                  = bus.core_waddr_valid_o & bus.core_waddr_ready_i;
  assign mode_o                 = state_q;

  // Starvation and batch counters live only while their mode persists.
  always_comb begin
    starve_d = '0;
    if (state_q == StRd && state_d == StRd) begin
      starve_d = starve_q;
      if (bus.waddr_valid_i && starve_q != StarveW'(MaxWStarve)) starve_d = starve_q + StarveW'(1);
    end
  end

  always_comb begin
    batch_d = '0;
    if (state_q == StWr && state_d == StWr) begin
      batch_d = batch_q;
      if (wr_hs && batch_q != BatchW'(WBatchLen)) batch_d = batch_q + BatchW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRd;
      target_q  <= StRd;
      turn_q    <= '0;
      starve_q  <= '0;
      batch_q   <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      turn_q    <= turn_d;
      starve_q  <= starve_d;
      batch_q   <= batch_d;
      rd_pend_q <= bus.core_raddr_valid_o & ~bus.core_raddr_ready_i;
      wr_pend_q <= bus.core_waddr_valid_o & ~bus.core_waddr_ready_i;
    end
  end

`ifdef SIMMEM_ADDR_SCHED_STATS_EN
  logic        rd_hs;
  logic [31:0] rd_cnt_q, wr_cnt_q, turn_cnt_q;

  assign rd_hs = bus.core_raddr_valid_o & bus.core_raddr_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      turn_cnt_q <= '0;
    end else begin
      if (rd_hs) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_hs) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (state_q != StTurn && state_d == StTurn) turn_cnt_q <= turn_cnt_q + 32'd1;
    end
  end

  assign stat_rd_grants_o = rd_cnt_q;
  assign stat_wr_grants_o = wr_cnt_q;
  assign stat_turns_o     = turn_cnt_q;
`else
  assign stat_rd_grants_o = '0;
  assign stat_wr_grants_o = '0;
  assign stat_turns_o     = '0;
`endif

endmodule

// File: tb/tb_simmem_addr_scheduler.sv
// Scoreboard bench for simmem_addr_scheduler: directed scenarios plus random traffic,
// checked against a cycle model of the scheduling rules and a few fixed traces.
module tb_simmem_addr_scheduler;
  localparam int unsigned TC = 2;
  localparam int unsigned WB = 4;
  localparam int unsigned MS = 8;
  localparam int LogN = 4096;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  mode;
  logic [31:0] st_rd, st_wr, st_turns;

  simmem_addr_scheduler_if bus();

  simmem_addr_scheduler #(.TurnCycles(TC), .WBatchLen(WB), .MaxWStarve(MS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .mode_o(mode),
    .stat_rd_grants_o(st_rd), .stat_wr_grants_o(st_wr), .stat_turns_o(st_turns)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        crv, rrdy, cwv, wrdy;
    logic [1:0]  mode;
    logic [31:0] srd, swr, sturn;
  } obs_t;

  typedef struct { int cyc; obs_t o; } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model state: 0 read mode, 1 write mode, 2 turnaround.
  int          m_mode = 0, m_tgt = 0, m_starve = 0, m_batch = 0, m_turn_left = 0;
  bit          m_rpend = 0, m_wpend = 0;
  int unsigned m_srd = 0, m_swr = 0, m_sturn = 0;

  int          mode_log  [LogN];
  bit          rhs_log   [LogN];
  bit          whs_log   [LogN];
  bit          crv_log   [LogN];
  int unsigned sturn_log [LogN];

  int exp_mode27 [20] = '{0,0,0,0,0,0,0,0,0,2,2,1,1,1,1,1,2,2,0,0};
  bit exp_rhs27  [20] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,1,1};
  bit exp_whs27  [20] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,0};

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One clock of stimulus; the expected outputs for this cycle go to the scoreboard.
  task automatic step(input bit rv, input bit wv, input bit crr, input bit cwr, input bit rst);
    exp_t e;
    bit   gr, gw, rhs, whs;
    int   nxt;
    @(posedge clk);
    #1;
    rst_ni                 = !rst;
    bus.raddr_valid_i      = rv;
    bus.waddr_valid_i      = wv;
    bus.core_raddr_ready_i = crr;
    bus.core_waddr_ready_i = cwr;
    gr = 0; gw = 0; nxt = m_mode;
    if (rst) begin
      m_mode = 0; nxt = 0; m_starve = 0; m_batch = 0; m_turn_left = 0;
      m_rpend = 0; m_wpend = 0; m_srd = 0; m_swr = 0; m_sturn = 0;
    end else begin
      case (m_mode)
        0: if (!m_rpend && wv && (!rv || m_starve == int'(MS))) begin
             nxt = 2; m_tgt = 1; m_turn_left = int'(TC);
           end else gr = 1;
        1: if (!m_wpend && rv && (!wv || m_batch == int'(WB))) begin
             nxt = 2; m_tgt = 0; m_turn_left = int'(TC);
           end else gw = 1;
        default: begin
          m_turn_left--;
          if (m_turn_left == 0) nxt = m_tgt;
        end
      endcase
    end
    e.cyc     = cyc;
    e.o.crv   = rv && gr;
    e.o.rrdy  = crr && gr;
    e.o.cwv   = wv && gw;
    e.o.wrdy  = cwr && gw;
    e.o.mode  = 2'(m_mode);
    e.o.srd   = m_srd;
    e.o.swr   = m_swr;
    e.o.sturn = m_sturn;
    q.push_back(e);
    if (!rst) begin
      rhs = rv && gr && crr;
      whs = wv && gw && cwr;
`ifdef SIMMEM_ADDR_SCHED_STATS_EN
      m_srd += 32'(rhs);
      m_swr += 32'(whs);
      if (nxt == 2 && m_mode != 2) m_sturn++;
`endif
      m_rpend = rv && gr && !crr;
      m_wpend = wv && gw && !cwr;
      if (m_mode == 0 && nxt == 0) m_starve = (m_starve + int'(wv) > int'(MS)) ? int'(MS) : m_starve + int'(wv);
      else m_starve = 0;
      if (m_mode == 1 && nxt == 1) m_batch = (m_batch + int'(whs) > int'(WB)) ? int'(WB) : m_batch + int'(whs);
      else m_batch = 0;
      m_mode = nxt;
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: pop one expectation per cycle and compare against what the DUT presents.
  obs_t a;
  exp_t e_mon;
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      e_mon  = q.pop_front();
      a.crv  = bus.core_raddr_valid_o;
      a.rrdy = bus.raddr_ready_o;
      a.cwv  = bus.core_waddr_valid_o;
      a.wrdy = bus.waddr_ready_o;
      a.mode = mode;
      a.srd  = st_rd;
      a.swr  = st_wr;
      a.sturn = st_turns;
      vectors++;
      if (a !== e_mon.o) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got crv%b rrdy%b cwv%b wrdy%b mode%0d stats %0d/%0d/%0d expected crv%b rrdy%b cwv%b wrdy%b mode%0d stats %0d/%0d/%0d",
                 e_mon.cyc, a.crv, a.rrdy, a.cwv, a.wrdy, a.mode, a.srd, a.swr, a.sturn,
                 e_mon.o.crv, e_mon.o.rrdy, e_mon.o.cwv, e_mon.o.wrdy, e_mon.o.mode,
                 e_mon.o.srd, e_mon.o.swr, e_mon.o.sturn);
      end
      if (e_mon.cyc < LogN) begin
        mode_log[e_mon.cyc]  = int'(mode);
        rhs_log[e_mon.cyc]   = bus.core_raddr_valid_o && bus.core_raddr_ready_i;
        whs_log[e_mon.cyc]   = bus.core_waddr_valid_o && bus.core_waddr_ready_i;
        crv_log[e_mon.cyc]   = bus.core_raddr_valid_o;
        sturn_log[e_mon.cyc] = st_turns;
      end
    end
  end

  initial begin
    int base, n_r, n_w, n_m, first_w;
    bus.raddr_valid_i = 0; bus.waddr_valid_i = 0;
    bus.core_raddr_ready_i = 0; bus.core_waddr_ready_i = 0;

    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1);

    // Reads only: ten back-to-back read handshakes, never leaving read mode.
    base = cyc;
    for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 0);
    settle();
    n_r = 0; n_w = 0; n_m = 0;
    for (int i = 0; i < 10; i++) begin
      n_r += int'(rhs_log[base+i]); n_w += int'(whs_log[base+i]);
      if (mode_log[base+i] != 0) n_m++;
    end
    chk("rd_only_read_hs", n_r, 10);
    chk("rd_only_write_hs", n_w, 0);
    chk("rd_only_mode_changes", n_m, 0);

    // Both valids from reset: starvation-forced switch, write batch, switch back.
    step(1, 1, 1, 1, 1);
    base = cyc;
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0);
    settle();
    n_m = 0; n_r = 0; n_w = 0;
    for (int i = 0; i < 20; i++) begin
      if (mode_log[base+i] != exp_mode27[i]) n_m++;
      if (rhs_log[base+i] != exp_rhs27[i]) n_r++;
      if (whs_log[base+i] != exp_whs27[i]) n_w++;
    end
    chk("both_valid_mode_trace_errs", n_m, 0);
    chk("both_valid_read_trace_errs", n_r, 0);
    chk("both_valid_write_trace_errs", n_w, 0);

    // Read stalled by core ready while starvation saturates: no switch until handshake.
    step(1, 1, 1, 1, 1);
    base = cyc;
    for (int i = 0; i < 14; i++) step(1, 1, !(i >= 6 && i <= 10), 1, 0);
    settle();
    n_r = 0; n_m = 0;
    for (int i = 6; i <= 10; i++) n_r += int'(crv_log[base+i]);
    for (int i = 0; i <= 12; i++) if (mode_log[base+i] != 0) n_m++;
    chk("stall_core_rvalid_held", n_r, 5);
    chk("stall_mode_changes", n_m, 0);
    chk("stall_release_read_hs", int'(rhs_log[base+11]), 1);
    chk("stall_then_turn_mode", mode_log[base+13], 2);

    // Writes only after reset: leave cycle, two turnaround cycles, then first write.
    step(0, 0, 1, 1, 1);
    base = cyc;
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0);
    settle();
    first_w = -1;
    for (int i = 5; i >= 0; i--) if (whs_log[base+i]) first_w = i;
    chk("wr_only_first_write_cycle", first_w, 3);
    chk("wr_only_mode_c1", mode_log[base+1], 2);
    chk("wr_only_mode_c2", mode_log[base+2], 2);
    chk("wr_only_mode_c3", mode_log[base+3], 1);

    // Reset while turning around: back to read mode with reads granted at once.
    step(1, 1, 1, 1, 1);
    base = cyc;
    for (int i = 0; i < 10; i++) step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 0);
    settle();
    chk("turn_reset_was_turning", mode_log[base+9], 2);
    chk("turn_reset_mode_after", mode_log[base+11], 0);
    chk("turn_reset_read_hs", int'(rhs_log[base+11]), 1);
    chk("turn_reset_stat_turns", int'(sturn_log[base+11]), 0);

    // Random traffic; requesters hold valid until accepted.
    for (int i = 0; i < 800; i++) begin
      bit rv, wv, rst;
      rst = ($urandom_range(0, 149) == 0);
      rv  = m_rpend ? 1'b1 : ($urandom_range(0, 3) != 0);
      wv  = m_wpend ? 1'b1 : ($urandom_range(0, 3) != 0);
      step(rv, wv, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rst);
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/simmem_addr_scheduler.md
SIMMEM_ADDR_SCHEDULER -- requirements
Module: simmem_addr_scheduler

Interface
REQ-001 SHALL have parameter TurnCycles, default 2: dead cycles inserted on every read/write direction switch; legal range 1..15.
REQ-002 SHALL have parameter WBatchLen, default 4: maximum consecutive write-address grants before yielding to a pending read; legal range 1..255.
REQ-003 SHALL have parameter MaxWStarve, default 8: cycles a pending write may wait in read mode before a forced switch; legal range 1..255.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-005 SHALL have ports: waddr_valid_i  in  1  requester write-address valid; waddr_ready_o  out  1  requester write-address ready.
REQ-006 SHALL have ports: raddr_valid_i  in  1  requester read-address valid; raddr_ready_o  out  1  requester read-address ready.
REQ-007 SHALL have ports: core_waddr_valid_o  out  1  write address to delay calculator; core_waddr_ready_i  in  1  its ready.
REQ-008 SHALL have ports: core_raddr_valid_o  out  1  read address to delay calculator; core_raddr_ready_i  in  1  its ready.
REQ-009 SHALL have port mode_o  out  2  FSM state: 0 RD, 1 WR, 2 TURN.
REQ-010 SHALL have ports stat_rd_grants_o, stat_wr_grants_o, stat_turns_o  out  32 each  statistics counters.

Function
REQ-011 SHALL gate handshakes only; address payloads bypass the block.
REQ-012 SHALL drive core_Xaddr_valid_o = Xaddr_valid_i AND grant_X, and Xaddr_ready_o = core_Xaddr_ready_i AND grant_X; grants never depend on any ready.
REQ-013 SHALL grant at most one direction per cycle; no grant in TURN.
REQ-014 SHALL, in RD, grant reads; starve_cnt increments (saturating at MaxWStarve) each RD cycle with waddr_valid_i high, and clears on leaving RD.
REQ-015 SHALL leave RD when waddr_valid_i && (!raddr_valid_i || starve_cnt == MaxWStarve) and no read is pending; the leaving cycle issues no grant; target WR.
REQ-016 SHALL, in WR, grant writes; batch_cnt clears on WR entry and increments on each write handshake, saturating at WBatchLen.
REQ-017 SHALL leave WR when raddr_valid_i && (!waddr_valid_i || batch_cnt == WBatchLen) and no write is pending; leaving cycle issues no grant; target RD.
REQ-018 SHALL hold a pending flag per direction, set when core valid is high without core ready, cleared on handshake; while set, state and grant are frozen (AXI valid stability).
REQ-019 SHALL, in TURN, load turn counter with TurnCycles-1 on entry, decrement per cycle, and enter the target state in the cycle after it reads 0 (exactly TurnCycles TURN cycles).
REQ-020 SHALL remain in RD/WR when neither switch condition holds, including both valids low.
REQ-021 SHALL, with both valids high in RD and starve_cnt < MaxWStarve, keep granting reads.

Reset
REQ-022 SHALL on rst_ni low asynchronously enter RD with starve_cnt, batch_cnt, turn counter, pending flags and stat counters cleared; all outputs 0 during reset.
REQ-023 SHALL, on reset mid-TURN or mid-pending-handshake, discard that state; the next grant follows RD rules.

Configuration
REQ-024 SHALL, with SIMMEM_ADDR_SCHED_STATS_EN defined, count read handshakes, write handshakes and TURN entries in stat_* (wrap modulo 2^32).
REQ-025 SHALL, without SIMMEM_ADDR_SCHED_STATS_EN, tie stat_* to 0 and instantiate no counter flops; scheduling is identical.

Verification
REQ-026 SHALL cover: reads only, core ready high, 10 cycles -> 10 read handshakes, mode_o stays 0, zero write grants.
REQ-027 SHALL cover: raddr and waddr valid continuously from reset, defaults -> 8 read grants, 1 no-grant cycle, 2 TURN cycles, 4 write grants, switch cycle, 2 TURN, reads resume.
REQ-028 SHALL cover: core_raddr_ready_i low 5 cycles while core_raddr_valid_o high and starve reached -> core_raddr_valid_o stays high, no switch until handshake.
REQ-029 SHALL cover: write only after RD reset -> 1 no-grant cycle, 2 TURN cycles, first write handshake in cycle 4.
REQ-030 SHALL cover: rst_ni low during TURN -> mode_o 0 next cycle, stat_turns_o 0 (macro on), read granted immediately.
REQ-031 SHALL cover: macro off, traffic of REQ-027 -> identical grant trace, stat_* constantly 0.
